// File: rtl/qkd_pkg.sv
// qkd_pkg: shared types and constants for the collapse bank.
// Cell/bank state enums, LFSR taps/seed, statistics counter width.
package qkd_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    ARMED     = 2'd1,
    COLLAPSED = 2'd2
  } cell_state_t;

  typedef enum logic {
    RUN    = 1'b0,
    KILLED = 1'b1
  } bank_state_t;

  // taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam int          CNT_W         = 16;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/qkd_lfsr.sv
// qkd_lfsr: 16-bit Fibonacci LFSR, advances every cycle.
// Ports: clk, reset_n (async low), lfsr (current state).
module qkd_lfsr
  import qkd_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] lfsr
);

  logic fb;

  assign fb = ^(lfsr & LFSR_TAPS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], fb};
    end
  end

endmodule

// File: rtl/qkd_collapse_bank.sv
// qkd_collapse_bank: DEPTH read-once secrets with basis tags and QBER abort.
// Ports: init/init_addr arm, rd_* measure, fuse_* kill, stats counters.
module qkd_collapse_bank
  import qkd_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter int          DEPTH        = 16,
  parameter int          BASIS_W      = 2,
  parameter int          MAX_MISMATCH = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         AW           = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               init,
  input  logic [AW-1:0]      init_addr,
  input  logic               rd_req,
  input  logic [AW-1:0]      rd_addr,
  input  logic [BASIS_W-1:0] rd_basis,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_hit,
  input  logic               fuse_blow,
  output logic               fuse_fire,
  output logic               pad_enable,
  output logic               killed,
  output logic [AW:0]        armed_count,
  output logic [CNT_W-1:0]   match_count,
  output logic [CNT_W-1:0]   mismatch_count
);

  logic [15:0]        lfsr;
  logic               unused_lfsr;
  logic [WIDTH-1:0]   secret;
  logic [BASIS_W-1:0] basis;

  cell_state_t        st_q  [DEPTH];
  logic [WIDTH-1:0]   val_q [DEPTH];
  logic [BASIS_W-1:0] bas_q [DEPTH];

  bank_state_t bank_q;
  bank_state_t bank_d;

  logic same;
  logic rd_armed;
  logic rd_match;
  logic rd_miss;
  logic abort;
  logic kill;
  logic do_init;

  qkd_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .lfsr   (lfsr)
  );

  assign unused_lfsr = ^lfsr;
  assign secret      = lfsr[WIDTH-1:0];
  assign basis       = lfsr[15 -: BASIS_W];

  assign killed  = (bank_q == KILLED);
  assign do_init = init & ~killed;

  // a read racing an init to the same cell never sees it armed
  assign same     = init & rd_req & (init_addr == rd_addr);
  assign rd_armed = rd_req & ~killed & ~same
                  & (st_q[rd_addr] == ARMED);
  assign rd_match = rd_armed & (bas_q[rd_addr] == rd_basis);
  assign rd_miss  = rd_armed & ~rd_match;

  assign abort = rd_miss
               & (MAX_MISMATCH != 0)
               & (mismatch_count != '1)
               & (mismatch_count + CNT_W'(1)
                  == CNT_W'(MAX_MISMATCH));

  always_comb begin
    bank_d = bank_q;
    unique case (bank_q)
      RUN:    if (fuse_blow || abort) bank_d = KILLED;
      KILLED: bank_d = KILLED;
    endcase
  end

  assign kill = (bank_q == RUN) & (bank_d == KILLED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= RUN;
    end else begin
      bank_q <= bank_d;
    end
  end

  // kill overrides any same-cycle init or collapse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= EMPTY;
        val_q[i] <= '0;
        bas_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill) begin
          st_q[i]  <= COLLAPSED;
          val_q[i] <= secret;
        end else if (do_init && init_addr == AW'(i)) begin
          st_q[i]  <= ARMED;
          val_q[i] <= secret;
          bas_q[i] <= basis;
        end else if (rd_armed && rd_addr == AW'(i)) begin
          st_q[i]  <= COLLAPSED;
          val_q[i] <= secret;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid       <= 1'b0;
      rd_hit         <= 1'b0;
      rd_data        <= '0;
      fuse_fire      <= 1'b0;
      match_count    <= '0;
      mismatch_count <= '0;
    end else begin
      rd_valid  <= rd_req;
      rd_hit    <= rd_match;
      rd_data   <= rd_match ? val_q[rd_addr] : secret;
      fuse_fire <= rd_armed | kill;
      if (rd_match) begin
        match_count <= sat_inc(match_count);
      end
      if (rd_miss) begin
        mismatch_count <= sat_inc(mismatch_count);
      end
    end
  end

  assign pad_enable = rd_valid & rd_hit & ~killed;

  always_comb begin
    armed_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] == ARMED) begin
        armed_count = armed_count + (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_qkd_collapse_bank.sv
// tb_qkd_collapse_bank: random + directed bench with a behavioural model.
// Model tracks cells, LFSR, counters; compare runs after every edge.
module tb_qkd_collapse_bank;

  localparam int W   = 8;
  localparam int D   = 16;
  localparam int BW  = 2;
  localparam int MM  = 4;
  localparam int AWT = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic           clk;
  logic           reset_n;
  logic           init;
  logic [AWT-1:0] init_addr;
  logic           rd_req;
  logic [AWT-1:0] rd_addr;
  logic [BW-1:0]  rd_basis;
  logic           rd_valid;
  logic [W-1:0]   rd_data;
  logic           rd_hit;
  logic           fuse_blow;
  logic           fuse_fire;
  logic           pad_enable;
  logic           killed;
  logic [AWT:0]   armed_count;
  logic [15:0]    match_count;
  logic [15:0]    mismatch_count;

  qkd_collapse_bank #(
    .WIDTH       (W),
    .DEPTH       (D),
    .BASIS_W     (BW),
    .MAX_MISMATCH(MM),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .init          (init),
    .init_addr     (init_addr),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_basis      (rd_basis),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_hit        (rd_hit),
    .fuse_blow     (fuse_blow),
    .fuse_fire     (fuse_fire),
    .pad_enable    (pad_enable),
    .killed        (killed),
    .armed_count   (armed_count),
    .match_count   (match_count),
    .mismatch_count(mismatch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // model: 0 empty, 1 armed, 2 collapsed
  int          mstate [D];
  logic [W-1:0]  mval [D];
  logic [BW-1:0] mbas [D];
  logic [15:0] mlfsr;
  bit          mkilled;
  int          mmatch;
  int          mmis;

  bit          e_valid;
  bit          e_hit;
  logic [W-1:0] e_data;
  bit          e_fire;
  bit          e_pad;
  bit          e_killed;
  int          e_armed;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      mstate[i] = 0;
      mval[i]   = '0;
      mbas[i]   = '0;
    end
    mlfsr   = SEED;
    mkilled = 0;
    mmatch  = 0;
    mmis    = 0;
  endtask

  task automatic model_step();
    int ra;
    int ia;
    bit same;
    bit arm_rd;
    bit hit;
    bit kill;
    logic [W-1:0] noise;
    ra    = int'(rd_addr);
    ia    = int'(init_addr);
    noise = mlfsr[W-1:0];
    same   = init && rd_req && (ia == ra);
    arm_rd = rd_req && !mkilled && !same && mstate[ra] == 1;
    hit    = arm_rd && (mbas[ra] == rd_basis);
    e_valid = rd_req;
    e_hit   = hit;
    e_data  = hit ? mval[ra] : noise;
    kill    = fuse_blow;
    if (arm_rd) begin
      mstate[ra] = 2;
      mval[ra]   = noise;
      if (hit) begin
        if (mmatch < 65535) mmatch++;
      end else if (mmis < 65535) begin
        mmis++;
        if (MM != 0 && mmis == MM) kill = 1;
      end
    end
    if (init && !mkilled) begin
      mstate[ia] = 1;
      mval[ia]   = noise;
      mbas[ia]   = mlfsr[15 -: BW];
    end
    if (mkilled) kill = 0;
    if (kill) begin
      for (int i = 0; i < D; i++) mstate[i] = 2;
      mkilled = 1;
    end
    e_fire   = arm_rd || kill;
    e_killed = mkilled;
    e_pad    = e_valid && e_hit && !mkilled;
    e_armed  = 0;
    for (int i = 0; i < D; i++) begin
      if (mstate[i] == 1) e_armed++;
    end
    mlfsr = lfsr_next(mlfsr);
  endtask

  task automatic compare();
    chk("rd_valid", 32'(rd_valid), 32'(e_valid));
    chk("rd_hit", 32'(rd_hit), 32'(e_hit));
    if (e_valid) chk("rd_data", 32'(rd_data), 32'(e_data));
    chk("fuse_fire", 32'(fuse_fire), 32'(e_fire));
    chk("pad_enable", 32'(pad_enable), 32'(e_pad));
    chk("killed", 32'(killed), 32'(e_killed));
    chk("armed_count", 32'(armed_count), 32'(e_armed));
    chk("match_count", 32'(match_count), 32'(mmatch));
    chk("mismatch_count", 32'(mismatch_count), 32'(mmis));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic drive(input bit i, input int ia,
                       input bit r, input int ra,
                       input int rb, input bit fb);
    init      = i;
    init_addr = AWT'(ia);
    rd_req    = r;
    rd_addr   = AWT'(ra);
    rd_basis  = BW'(rb);
    fuse_blow = fb;
  endtask

  task automatic zero_chk();
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_hit", 32'(rd_hit), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_fire", 32'(fuse_fire), 0);
    chk("rst_pad", 32'(pad_enable), 0);
    chk("rst_killed", 32'(killed), 0);
    chk("rst_armed", 32'(armed_count), 0);
    chk("rst_match", 32'(match_count), 0);
    chk("rst_mis", 32'(mismatch_count), 0);
  endtask

  // called 1 time unit after a rising edge
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    zero_chk();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // init 3 then correct-basis read: secret E1, basis 2
    chk("pin_seed", 32'(mlfsr), 32'h0000ACE1);
    drive(1, 3, 0, 0, 0, 0);
    cycle();
    chk("pin_lfsr1", 32'(mlfsr), 32'h000059C3);
    chk("init3_armed", 32'(armed_count), 1);
    drive(0, 0, 1, 3, 2, 0);
    cycle();
    chk("rd3_valid", 32'(rd_valid), 1);
    chk("rd3_hit", 32'(rd_hit), 1);
    chk("rd3_data", 32'(rd_data), 32'h000000E1);
    chk("rd3_fire", 32'(fuse_fire), 1);
    chk("rd3_match", 32'(match_count), 1);
    chk("rd3_armed", 32'(armed_count), 0);
    chk("rd3_pad", 32'(pad_enable), 1);

    // re-read: collapsed
    drive(0, 0, 1, 3, 2, 0);
    cycle();
    chk("rr3_hit", 32'(rd_hit), 0);
    chk("rr3_ne", 32'(rd_data != 8'hE1), 1);
    chk("rr3_fire", 32'(fuse_fire), 0);
    chk("rr3_match", 32'(match_count), 1);
    chk("rr3_mis", 32'(mismatch_count), 0);

    // QBER abort after 4 wrong-basis reads
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i <= 4; i++) begin
      drive(1, i, 0, 0, 0, 0);
      cycle();
    end
    chk("ab_armed5", 32'(armed_count), 5);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, i, int'(mbas[i] ^ 2'b01), 0);
      cycle();
      if (i == 2) chk("ab_alive3", 32'(killed), 0);
    end
    chk("ab_killed", 32'(killed), 1);
    chk("ab_fire", 32'(fuse_fire), 1);
    chk("ab_mis", 32'(mismatch_count), 4);
    chk("ab_armed0", 32'(armed_count), 0);
    drive(1, 5, 0, 0, 0, 0);
    cycle();
    chk("ab_noinit", 32'(armed_count), 0);
    drive(0, 0, 1, 4, int'(mbas[4]), 0);
    cycle();
    chk("ab_rd4_hit", 32'(rd_hit), 0);

    // same-cycle init and read of cell 7
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 7, 1, 7, 0, 0);
    cycle();
    chk("c7_valid", 32'(rd_valid), 1);
    chk("c7_hit", 32'(rd_hit), 0);
    chk("c7_fire", 32'(fuse_fire), 0);
    chk("c7_armed", 32'(armed_count), 1);

    // fuse_blow with a correct-basis read
    drive(1, 2, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 1, 2, int'(mbas[2]), 1);
    cycle();
    chk("fb_hit", 32'(rd_hit), 1);
    chk("fb_pad", 32'(pad_enable), 0);
    chk("fb_killed", 32'(killed), 1);
    chk("fb_fire", 32'(fuse_fire), 1);
    chk("fb_armed", 32'(armed_count), 0);

    // random traffic with occasional resets
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        init      = ($urandom_range(0, 2) == 0);
        init_addr = AWT'($urandom_range(0, 7));
        rd_req    = ($urandom_range(0, 1) == 1);
        rd_addr   = AWT'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) rd_basis = mbas[rd_addr];
        else rd_basis = BW'($urandom_range(0, 3));
        fuse_blow = ($urandom_range(0, 299) == 0);
        cycle();
      end
    end

    // reset in the middle of a read burst
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    cycle();
    for (int n = 0; n < 3; n++) begin
      drive(0, 0, 1, 1, int'(mbas[1]), 0);
      cycle();
    end
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 1, 0, int'(mbas[0]), 0);
    cycle();
    chk("post_hit", 32'(rd_hit), 1);
    chk("post_data", 32'(rd_data), 32'h000000E1);
    chk("post_match", 32'(match_count), 1);
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qkd_collapse_bank.md
# qkd_collapse_bank

Parametrised, multi-cell successor to the single-cell BB84 collapse register. Holds DEPTH independently addressed read-once secrets, each with its own random basis tag. Any first read of an armed cell collapses it. Per-cell results are registered with one-cycle latency. The block also keeps basis-match/mismatch statistics and self-kills the whole bank when mismatches reach an abort threshold (eavesdropper/QBER abort). It sits between the key-generation TRNG path and the I/O pad driver.

## Interface
Parameters:
- WIDTH, 8: secret width per cell, 1..16.
- DEPTH, 16: number of cells, power of two, 2..256.
- BASIS_W, 2: basis tag width, 1..4.
- MAX_MISMATCH, 4: wrong-basis reads that trigger a bank-wide abort; 0 disables the abort.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports (AW = $clog2(DEPTH)):
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init  in  1  arm cell init_addr with a fresh secret and basis.
- init_addr  in  AW  cell to arm.
- rd_req  in  1  single-cycle read (measurement) strobe.
- rd_addr  in  AW  cell to read.
- rd_basis  in  BASIS_W  reader's measurement basis.
- rd_valid  out  1  response strobe, exactly one cycle after rd_req.
- rd_data  out  WIDTH  true secret if rd_hit, otherwise LFSR noise.
- rd_hit  out  1  response carries the true value.
- fuse_blow  in  1  external kill request.
- fuse_fire  out  1  one-cycle OTP trigger pulse.
- pad_enable  out  1  pad output enable; high only with a hit while not killed.
- killed  out  1  bank permanently dead until reset.
- armed_count  out  AW+1  number of cells currently ARMED.
- match_count, mismatch_count  out  16 each  saturating statistics counters.

## Operation
- Per-cell state: EMPTY → ARMED (on init) → COLLAPSED (on read). Init re-arms a COLLAPSED cell to ARMED. Bank state: RUN → KILLED. KILLED is left only by reset.
- LFSR: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle. Secret = lfsr[WIDTH-1:0]. Basis = lfsr[15 -: BASIS_W].
- Init (RUN only): the target cell loads the secret and basis and becomes ARMED. Init is ignored while KILLED.
- Read of an ARMED cell in RUN:
  - The cell goes to COLLAPSED, its value is overwritten with LFSR noise, and fuse_fire pulses.
  - If the basis matches: rd_hit=1, rd_data=stored value, match_count+1.
  - Otherwise: rd_hit=0, rd_data=noise, mismatch_count+1.
- Read of an EMPTY or COLLAPSED cell, or any read while KILLED: rd_hit=0, noise, no counter change, no fuse_fire.
- Abort: when the mismatch_count increment makes it equal MAX_MISMATCH (and MAX_MISMATCH≠0), set KILLED. fuse_blow also sets KILLED.
- Entering KILLED forces every cell to COLLAPSED. fuse_fire pulses once on entry, OR-merged with any same-cycle collapse pulse.
- Simultaneous init and read of the same address: the read is treated as non-ARMED (noise, no collapse) and the init wins. Different addresses are handled independently.
- Simultaneous fuse_blow and read: the read is evaluated against the pre-kill state, and its response is still delivered. pad_enable is 0 for that response because killed is already set.
- Counters saturate at 16'hFFFF. armed_count reflects the state after each edge.

## Timing
- Reset values: every output 0, all cells EMPTY, counters 0, lfsr=LFSR_SEED.
- Read latency 1: rd_req at edge N → rd_valid/rd_data/rd_hit valid for the cycle after edge N. The cell state, counters, killed and fuse_fire update on the same edge N.
- pad_enable = rd_valid & rd_hit & ~killed, all registered terms.
- Back-to-back rd_req every cycle is supported, including to the same address; the second read sees COLLAPSED.
- Asserting reset_n mid-operation clears everything immediately, including KILLED.

## Structure
- Package qkd_pkg holds:
  - cell_state_t enum {EMPTY, ARMED, COLLAPSED};
  - LFSR tap constant and default seed;
  - the 16-bit counter width constant.
- Sub-module qkd_lfsr (16-bit, seed parameter) is shared with other ROOM blocks.
- Cell storage is a flop array; it is not inferred RAM, because the kill must collapse all cells in one cycle.

## Test plan
- Reset, init cell 3, then read cell 3 with the correct basis → rd_valid next cycle, rd_hit=1, value equals the LFSR sample at init, fuse_fire=1, match_count=1, armed_count=0.
- Re-read cell 3 → rd_hit=0, data≠secret, no fuse_fire, counters unchanged.
- Init cells 0–4, then wrong-basis reads on 0–3 with MAX_MISMATCH=4 → killed=1 after the 4th read, cell 4 COLLAPSED, armed_count=0, a later init is ignored.
- Init and read of cell 7 in the same cycle → noise, cell 7 ARMED, armed_count=1.
- fuse_blow in the same cycle as a correct-basis read → rd_hit=1, pad_enable=0, killed=1.
- Assert reset_n mid-read burst → all outputs 0; a fresh init/read on cell 0 then succeeds.
